bsg_chip_link_token_tx: RTL and testbench
=========================================

// Module: bsg_chip_link_token_tx
//
// PURPOSE
// - Credit-based transmit stage for one outgoing comm-link channel (co or co2).
// - Sits directly upstream of the chip swizzle adapter and drives its guts_co*
//   inputs (v, 9-bit data); consumes the matching guts_co*_tkn_o token line.
// - Accepts core-side words on a valid/ready handshake and forwards them as
//   registered link beats. Each beat consumes one credit; each token-line
//   transition returns one credit.
//
// PARAMETERS
// - channel_width_p   9   link data width; must equal the pad-channel width.
// - credits_p         8   credits at reset; equals the receiver FIFO depth; >=1.
// - lg_credits_lp     $clog2(credits_p+1)   credit counter width (local).
//
// PORTS
// - clk_i          in   1                core/link clock
// - reset_i        in   1                synchronous, active-high reset
// - v_i            in   1                core word valid
// - data_i         in   channel_width_p  core word
// - ready_o        out  1                core word accepted when v_i & ready_o
// - link_v_o       out  1                link beat valid (to guts_co*_v_i)
// - link_data_o    out  channel_width_p  link beat data (to guts_co*_data_i)
// - link_tkn_i     in   1                token toggle from receiver (async)
// - credit_cnt_o   out  lg_credits_lp    current credits, for debug/monitor
// - credit_err_o   out  1                sticky: credit returned with counter full
//
// BEHAVIOUR
// - Reset (reset_i=1 at a clk_i edge):
//   - link_v_o=0, link_data_o=0, credit_cnt=credits_p, credit_err_o=0.
//   - Synchronizer and edge-history flops are loaded with 0.
//   - ready_o is forced to 0 while reset_i=1.
// - ready_o = ~reset_i & (credit_cnt != 0). It is combinational from registered
//   state only and never depends on v_i.
// - Send: if v_i & ready_o at edge N, then from N+1 link_v_o=1 and
//   link_data_o=data_i. Latency is one cycle, giving one beat per cycle at most.
// - Idle: when there is no send, link_v_o=0 and link_data_o holds its last value
//   (no pad toggling).
// - Token return:
//   - link_tkn_i passes through a 2-flop synchronizer, then a history flop.
//   - A rising or falling edge on sync2 vs history is one credit.
//   - The credit is added at the edge after sync2 changes, i.e. the 3rd edge
//     after link_tkn_i is first sampled changed.
//   - Toggle spacing is at least 3 clk_i cycles; this is a receiver contract.
// - Credit update on every non-reset edge:
//   - send & ~ret  -> cnt-1
//   - ~send & ret  -> cnt+1
//   - both or none -> unchanged
// - Boundary conditions:
//   - At cnt=0 with no return, nothing is sent. With a same-cycle return, the
//     send waits one cycle because ready_o uses the registered cnt.
//   - ret with cnt=credits_p and no send: cnt saturates at credits_p and
//     credit_err_o is set until reset.
//   - Reset mid-transfer: the in-flight beat is dropped (link_v_o=0 next cycle)
//     and credits are restored to credits_p. The receiver must be reset in the
//     same window.
//
// TESTING
// - Reset: apply reset_i for 3 cycles with v_i=1 -> ready_o=0, link_v_o=0,
//   credit_cnt_o=8; first cycle after reset ready_o=1.
// - Streaming: send 8 words 0x001..0x008 back-to-back, no tokens -> 8 beats on
//   consecutive cycles, each one cycle after accept; then ready_o=0 and
//   credit_cnt_o=0.
// - Credit return: at cnt=0, toggle link_tkn_i once -> cnt=1 within 3 cycles;
//   the next word 0x1A5 is sent; cnt returns to 0.
// - Simultaneous event: at cnt=4, accept a word on the same edge that a token
//   edge is detected -> cnt stays 4 and a beat is emitted.
// - Overflow: at cnt=8 with no traffic, toggle link_tkn_i -> cnt stays 8 and
//   credit_err_o=1; it stays 1 until reset_i.
// - Random: random v_i and token returns modelling an 8-deep receiver ->
//   scoreboard matches data order, no loss; cnt is always in 0..8.

Source files
------------

// File: rtl/bsg_chip_link_token_tx.sv
// rtl/bsg_chip_link_token_tx.sv - credit-based transmit stage for one comm-link channel
// Forwards core words as registered link beats; token-line toggles return credits.
module bsg_chip_link_token_tx #(
  parameter int channel_width_p = 9,
  parameter int credits_p       = 8,
  localparam int lg_credits_lp  = $clog2(credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [channel_width_p-1:0] data_i,
  output logic                       ready_o,
  output logic                       link_v_o,
  output logic [channel_width_p-1:0] link_data_o,
  input  logic                       link_tkn_i,
  output logic [lg_credits_lp-1:0]   credit_cnt_o,
  output logic                       credit_err_o
);

  localparam logic [lg_credits_lp-1:0] max_credits_lp = lg_credits_lp'(credits_p);

  logic [lg_credits_lp-1:0] credit_cnt_r;
  logic                     tkn_sync1_r;
  logic                     tkn_sync2_r;
  logic                     tkn_hist_r;
  logic                     credit_err_r;
  logic                     send;
  logic                     ret;

  // ready_o looks only at registered credits, so a same-cycle return cannot
  // unblock a send until the following cycle.
  assign ready_o      = ~reset_i & (credit_cnt_r != '0);
  assign send         = v_i & ready_o;
  assign ret          = tkn_sync2_r ^ tkn_hist_r;
  assign credit_cnt_o = credit_cnt_r;
  assign credit_err_o = credit_err_r;

  // The token line is asynchronous to clk_i; every transition is one credit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tkn_sync1_r <= 1'b0;
      tkn_sync2_r <= 1'b0;
      tkn_hist_r  <= 1'b0;
    end else begin
      tkn_sync1_r <= link_tkn_i;
      tkn_sync2_r <= tkn_sync1_r;
      tkn_hist_r  <= tkn_sync2_r;
    end
  end

  // Data holds its last value when idle to avoid toggling the pads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      link_v_o    <= 1'b0;
      link_data_o <= '0;
    end else begin
      link_v_o <= send;
      if (send) begin
        link_data_o <= data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credit_cnt_r <= max_credits_lp;
      credit_err_r <= 1'b0;
    end else if (send & ~ret) begin
      credit_cnt_r <= credit_cnt_r - 1'b1;
    end else if (~send & ret) begin
      // A return with a full counter means the receiver miscounted.
      if (credit_cnt_r == max_credits_lp) begin
        credit_err_r <= 1'b1;
      end else begin
        credit_cnt_r <= credit_cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bsg_chip_link_token_tx.sv
// tb/tb_bsg_chip_link_token_tx.sv - directed and random checks for bsg_chip_link_token_tx
module tb_bsg_chip_link_token_tx;

  logic       clk;
  logic       reset_i;
  logic       v_i;
  logic [8:0] data_i;
  logic       ready_o;
  logic       link_v_o;
  logic [8:0] link_data_o;
  logic       link_tkn_i;
  logic [3:0] credit_cnt_o;
  logic       credit_err_o;

  int total;
  int bad;
  logic tkn;

  bsg_chip_link_token_tx #(
    .channel_width_p(9),
    .credits_p(8)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .v_i(v_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .link_v_o(link_v_o),
    .link_data_o(link_data_o),
    .link_tkn_i(link_tkn_i),
    .credit_cnt_o(credit_cnt_o),
    .credit_err_o(credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic toggle_tkn();
    tkn = ~tkn;
    link_tkn_i = tkn;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    v_i = 1'b1;
    data_i = 9'h1FF;
    tkn = 1'b0;
    link_tkn_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0d exp=0", ready_o); end
      total++; if (link_v_o !== 1'b0) begin bad++; $display("FAIL reset_link_v got=%0d exp=0", link_v_o); end
      total++; if (credit_cnt_o !== 4'd8) begin bad++; $display("FAIL reset_cnt got=%0d exp=8", credit_cnt_o); end
      total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%0d exp=0", credit_err_o); end
    end
    total++; if (link_data_o !== 9'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", link_data_o); end
    reset_i = 1'b0;
    v_i = 1'b0;
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0d exp=1", ready_o); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      data_i = 9'(i);
      v_i = 1'b1;
      @(negedge clk);
      total++; if (link_v_o !== 1'b1) begin bad++; $display("FAIL stream_v[%0d] got=%0d exp=1", i, link_v_o); end
      total++; if (link_data_o !== 9'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, link_data_o, 9'(i)); end
      total++; if (credit_cnt_o !== 4'(8 - i)) begin bad++; $display("FAIL stream_cnt[%0d] got=%0d exp=%0d", i, credit_cnt_o, 8 - i); end
    end
    data_i = 9'h0FF;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL stream_empty_ready got=%0d exp=0", ready_o); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (link_v_o !== 1'b0) begin bad++; $display("FAIL starved_v got=%0d exp=0", link_v_o); end
      total++; if (link_data_o !== 9'h008) begin bad++; $display("FAIL starved_hold got=%h exp=008", link_data_o); end
      total++; if (credit_cnt_o !== 4'd0) begin bad++; $display("FAIL starved_cnt got=%0d exp=0", credit_cnt_o); end
    end
    v_i = 1'b0;
  endtask

  task automatic test_credit_return();
    int n;
    toggle_tkn();
    n = 0;
    while (credit_cnt_o == 4'd0 && n < 6) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== 3) begin bad++; $display("FAIL ret_latency got=%0d exp=3", n); end
    total++; if (credit_cnt_o !== 4'd1) begin bad++; $display("FAIL ret_cnt got=%0d exp=1", credit_cnt_o); end
    data_i = 9'h1A5;
    v_i = 1'b1;
    @(negedge clk);
    v_i = 1'b0;
    total++; if (link_v_o !== 1'b1) begin bad++; $display("FAIL ret_send_v got=%0d exp=1", link_v_o); end
    total++; if (link_data_o !== 9'h1A5) begin bad++; $display("FAIL ret_send_data got=%h exp=1a5", link_data_o); end
    total++; if (credit_cnt_o !== 4'd0) begin bad++; $display("FAIL ret_send_cnt got=%0d exp=0", credit_cnt_o); end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 4; k++) begin
      toggle_tkn();
      repeat (3) @(negedge clk);
    end
    total++; if (credit_cnt_o !== 4'd4) begin bad++; $display("FAIL sim_pre_cnt got=%0d exp=4", credit_cnt_o); end
    toggle_tkn();
    repeat (2) @(negedge clk);
    total++; if (credit_cnt_o !== 4'd4) begin bad++; $display("FAIL sim_mid_cnt got=%0d exp=4", credit_cnt_o); end
    data_i = 9'h0C3;
    v_i = 1'b1;
    @(negedge clk);
    v_i = 1'b0;
    total++; if (link_v_o !== 1'b1) begin bad++; $display("FAIL sim_v got=%0d exp=1", link_v_o); end
    total++; if (link_data_o !== 9'h0C3) begin bad++; $display("FAIL sim_data got=%h exp=0c3", link_data_o); end
    total++; if (credit_cnt_o !== 4'd4) begin bad++; $display("FAIL sim_cnt got=%0d exp=4", credit_cnt_o); end
    @(negedge clk);
    total++; if (credit_cnt_o !== 4'd4) begin bad++; $display("FAIL sim_after_cnt got=%0d exp=4", credit_cnt_o); end
    total++; if (link_v_o !== 1'b0) begin bad++; $display("FAIL sim_after_v got=%0d exp=0", link_v_o); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 4; k++) begin
      toggle_tkn();
      repeat (3) @(negedge clk);
    end
    total++; if (credit_cnt_o !== 4'd8) begin bad++; $display("FAIL ovf_pre_cnt got=%0d exp=8", credit_cnt_o); end
    total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL ovf_pre_err got=%0d exp=0", credit_err_o); end
    toggle_tkn();
    repeat (3) @(negedge clk);
    total++; if (credit_cnt_o !== 4'd8) begin bad++; $display("FAIL ovf_cnt got=%0d exp=8", credit_cnt_o); end
    total++; if (credit_err_o !== 1'b1) begin bad++; $display("FAIL ovf_err got=%0d exp=1", credit_err_o); end
    repeat (5) @(negedge clk);
    data_i = 9'h055;
    v_i = 1'b1;
    @(negedge clk);
    total++; if (credit_err_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d exp=1", credit_err_o); end
    total++; if (credit_cnt_o !== 4'd7) begin bad++; $display("FAIL ovf_send_cnt got=%0d exp=7", credit_cnt_o); end
    total++; if (link_v_o !== 1'b1) begin bad++; $display("FAIL ovf_send_v got=%0d exp=1", link_v_o); end
    reset_i = 1'b1;
    tkn = 1'b0;
    link_tkn_i = 1'b0;
    @(negedge clk);
    total++; if (link_v_o !== 1'b0) begin bad++; $display("FAIL midreset_v got=%0d exp=0", link_v_o); end
    total++; if (credit_cnt_o !== 4'd8) begin bad++; $display("FAIL midreset_cnt got=%0d exp=8", credit_cnt_o); end
    total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL midreset_err got=%0d exp=0", credit_err_o); end
    v_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    logic [8:0] w;
    int since_tkn;
    int sent;
    int got;
    since_tkn = 3;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (link_v_o === 1'b1) begin
        got++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra_beat got=%h exp=none", link_data_o);
        end else begin
          w = exp_q.pop_front();
          if (link_data_o !== w) begin bad++; $display("FAIL rand_data got=%h exp=%h", link_data_o, w); end
        end
        rx_q.push_back(link_data_o);
      end
      total++; if (rx_q.size() > 8) begin bad++; $display("FAIL rand_rx_overflow got=%0d exp<=8", rx_q.size()); end
      total++; if (credit_cnt_o > 4'd8) begin bad++; $display("FAIL rand_cnt_range got=%0d exp<=8", credit_cnt_o); end
      since_tkn++;
      if (rx_q.size() != 0 && since_tkn >= 3 && $urandom_range(0, 2) == 0) begin
        w = rx_q.pop_front();
        toggle_tkn();
        since_tkn = 0;
      end
      if (cyc < 500) begin
        v_i = 1'($urandom_range(0, 1));
        data_i = 9'($urandom_range(0, 511));
      end else begin
        v_i = 1'b0;
      end
      if (v_i && ready_o) begin
        exp_q.push_back(data_i);
        sent++;
      end
    end
    total++; if (got !== sent) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got, sent); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rand_lost got=%0d exp=0", exp_q.size()); end
    total++; if (credit_cnt_o !== 4'd8) begin bad++; $display("FAIL rand_final_cnt got=%0d exp=8", credit_cnt_o); end
    total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL rand_final_err got=%0d exp=0", credit_err_o); end
    total++; if (sent < 20) begin bad++; $display("FAIL rand_activity got=%0d exp>=20", sent); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_streaming();
    test_credit_return();
    test_simultaneous();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
